// File: rtl/adam_jtag_pkg.sv
// adam_jtag_pkg: TAP state encoding, instruction codes and the TAP next-state function
package adam_jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PA_DR  = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PA_IR  = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_t;

    localparam logic [4:0] INSTR_IDCODE = 5'h01;
    localparam logic [4:0] INSTR_PAUSE  = 5'h10;
    localparam logic [4:0] INSTR_BYPASS = 5'h1F;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_next = TLR;
        case (s)
            TLR:    tap_next = tms ? TLR    : RTI;
            RTI:    tap_next = tms ? SEL_DR : RTI;
            SEL_DR: tap_next = tms ? SEL_IR : CAP_DR;
            CAP_DR: tap_next = tms ? EX1_DR : SH_DR;
            SH_DR:  tap_next = tms ? EX1_DR : SH_DR;
            EX1_DR: tap_next = tms ? UPD_DR : PA_DR;
            PA_DR:  tap_next = tms ? EX2_DR : PA_DR;
            EX2_DR: tap_next = tms ? UPD_DR : SH_DR;
            UPD_DR: tap_next = tms ? SEL_DR : RTI;
            SEL_IR: tap_next = tms ? TLR    : CAP_IR;
            CAP_IR: tap_next = tms ? EX1_IR : SH_IR;
            SH_IR:  tap_next = tms ? EX1_IR : SH_IR;
            EX1_IR: tap_next = tms ? UPD_IR : PA_IR;
            PA_IR:  tap_next = tms ? EX2_IR : PA_IR;
            EX2_IR: tap_next = tms ? UPD_IR : SH_IR;
            UPD_IR: tap_next = tms ? SEL_DR : RTI;
            default: tap_next = TLR;
        endcase
    endfunction

endpackage

// File: rtl/adam_jtag_sync.sv
// adam_jtag_sync: STAGES-deep async-reset bit synchronizer
//   clk, rst : system clock and async active-high reset (flops clear to 0)
//   d_i      : asynchronous input bit
//   q_o      : synchronized output bit
module adam_jtag_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff_q <= '0;
        else     ff_q <= {ff_q[STAGES-2:0], d_i};
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/adam_jtag_pause_tap.sv
// adam_jtag_pause_tap: oversampled JTAG TAP with IDCODE, BYPASS and a PAUSE req/ack data register
//   clk, rst         : system clock (>= 4x tck), async active-high reset
//   jtag_trst_n      : async test reset, active low
//   jtag_tck/tms/tdi : JTAG pins, sampled as data
//   jtag_tdo         : JTAG data out, updated on synced tck falls
//   pause_req        : pause request to downstream, pause_ack its acknowledge
//   tap_state        : current TAP state encoding
module adam_jtag_pause_tap #(
    parameter logic [31:0] IDCODE      = 32'h0000_0001,
    parameter int          IR_WIDTH    = 5,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       jtag_trst_n,
    input  logic       jtag_tck,
    input  logic       jtag_tms,
    input  logic       jtag_tdi,
    output logic       jtag_tdo,
    output logic       pause_req,
    input  logic       pause_ack,
    output logic [3:0] tap_state
);
    import adam_jtag_pkg::*;

    logic tck_s, tms_s, tdi_s, trst_n_s, tck_prev_q, rise, fall, is_id, is_pause, tdo_q, req_q;
    tap_state_t state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q;
    logic [31:0] shift_q, shift_d;

    adam_jtag_sync #(.STAGES(SYNC_STAGES)) u_sync_tck  (.clk(clk), .rst(rst), .d_i(jtag_tck),    .q_o(tck_s));
    adam_jtag_sync #(.STAGES(SYNC_STAGES)) u_sync_tms  (.clk(clk), .rst(rst), .d_i(jtag_tms),    .q_o(tms_s));
    adam_jtag_sync #(.STAGES(SYNC_STAGES)) u_sync_tdi  (.clk(clk), .rst(rst), .d_i(jtag_tdi),    .q_o(tdi_s));
    adam_jtag_sync #(.STAGES(SYNC_STAGES)) u_sync_trst (.clk(clk), .rst(rst), .d_i(jtag_trst_n), .q_o(trst_n_s));

    assign rise     = tck_s & ~tck_prev_q;
    assign fall     = ~tck_s & tck_prev_q;
    assign is_id    = ir_q == IR_WIDTH'(INSTR_IDCODE);
    assign is_pause = ir_q == IR_WIDTH'(INSTR_PAUSE);
    assign state_d  = tap_next(state_q, tms_s);

    // Shift register next value for a rise in the current state; any code other
    // than IDCODE/PAUSE gets the 1-bit bypass register.
    always_comb begin
        shift_d = shift_q;
        case (state_q)
            CAP_IR: shift_d = 32'd1;
            CAP_DR: shift_d = is_id ? IDCODE : is_pause ? {30'b0, pause_ack, req_q} : '0;
            SH_IR:  shift_d = 32'(shift_q[IR_WIDTH-1:1]) | (32'(tdi_s) << (IR_WIDTH - 1));
            SH_DR:  shift_d = is_id ? {tdi_s, shift_q[31:1]} : is_pause ? {30'b0, tdi_s, shift_q[1]} : {31'b0, tdi_s};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TLR;
            ir_q       <= IR_WIDTH'(INSTR_IDCODE);
            shift_q    <= '0;
            tdo_q      <= 1'b0;
            req_q      <= 1'b0;
            tck_prev_q <= 1'b0;
        end else begin
            tck_prev_q <= tck_s;
            if (fall) tdo_q <= (state_q == SH_DR || state_q == SH_IR) & shift_q[0];
            // Test reset overrides any concurrent tck rise and drops shift contents.
            if (!trst_n_s) begin
                state_q <= TLR;
                ir_q    <= IR_WIDTH'(INSTR_IDCODE);
                req_q   <= 1'b0;
                shift_q <= '0;
            end else if (rise) begin
                state_q <= state_d;
                shift_q <= shift_d;
                if (state_q == UPD_IR) ir_q <= shift_q[IR_WIDTH-1:0];
                if (state_q == UPD_DR && is_pause) req_q <= shift_q[0];
                if (state_d == TLR) begin
                    ir_q  <= IR_WIDTH'(INSTR_IDCODE);
                    req_q <= 1'b0;
                end
            end
        end
    end

    assign jtag_tdo  = tdo_q;
    assign pause_req = req_q;
    assign tap_state = state_q;

endmodule

// File: tb/tb_adam_jtag_pause_tap.sv
// tb_adam_jtag_pause_tap: directed bench for the oversampled pause TAP
module tb_adam_jtag_pause_tap;

    logic       clk = 1'b0;
    logic       rst;
    logic       jtag_trst_n, jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;
    logic       pause_req, pause_ack;
    logic [3:0] tap_state;
    logic [31:0] dout;
    int checks = 0;
    int errors = 0;

    adam_jtag_pause_tap #(.IDCODE(32'hDEAD_BEEF), .IR_WIDTH(5), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .jtag_trst_n(jtag_trst_n), .jtag_tck(jtag_tck),
        .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
        .pause_req(pause_req), .pause_ack(pause_ack), .tap_state(tap_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One tck period of 8 clk; returns tdo as seen just before the rise.
    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
        @(negedge clk);
        tdo = jtag_tdo;
        jtag_tms = tms;
        jtag_tdi = tdi;
        jtag_tck = 1'b1;
        repeat (4) @(negedge clk);
        jtag_tck = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic tms_seq(input logic [7:0] bits, input int n);
        logic b;
        for (int i = 0; i < n; i++) tck_cycle(bits[i], 1'b0, b);
    endtask

    task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] d);
        logic b;
        d = '0;
        tms_seq(8'b001, 3);
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], b);
            d[i] = b;
        end
        tms_seq(8'b01, 2);
    endtask

    task automatic shift_ir(input logic [4:0] din, output logic [31:0] d);
        logic b;
        d = '0;
        tms_seq(8'b0011, 4);
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, din[i], b);
            d[i] = b;
        end
        tms_seq(8'b01, 2);
    endtask

    initial begin
        rst = 1'b1; jtag_trst_n = 1'b1; jtag_tck = 1'b0; jtag_tms = 1'b1; jtag_tdi = 1'b0; pause_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(tap_state), 32'd0);
        chk("rst_req", 32'(pause_req), 32'd0);
        chk("rst_tdo", 32'(jtag_tdo), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tms_seq(8'h1F, 5);
        chk("tlr_hold", 32'(tap_state), 32'd0);
        tms_seq(8'b0010, 4);
        chk("to_sh_dr", 32'(tap_state), 32'd4);
        tms_seq(8'h1F, 5);
        chk("five_tms", 32'(tap_state), 32'd0);
        tms_seq(8'b0, 1);
        chk("rti", 32'(tap_state), 32'd1);
        shift_dr(32, 32'h0, dout);
        chk("idcode", dout, 32'hDEAD_BEEF);
        chk("dr_rti", 32'(tap_state), 32'd1);
        shift_ir(5'h10, dout);
        chk("ir_cap", dout, 32'h1);
        shift_dr(2, 32'b01, dout);
        chk("pause_cap0", dout, 32'h0);
        chk("req_set", 32'(pause_req), 32'd1);
        pause_ack = 1'b1;
        shift_dr(2, 32'b01, dout);
        chk("pause_cap1", dout, 32'h3);
        chk("req_hold", 32'(pause_req), 32'd1);
        @(negedge clk);
        jtag_trst_n = 1'b0;
        repeat (16) @(negedge clk);
        chk("trst_state", 32'(tap_state), 32'd0);
        chk("trst_req", 32'(pause_req), 32'd0);
        jtag_trst_n = 1'b1;
        pause_ack = 1'b0;
        repeat (4) @(negedge clk);
        tms_seq(8'b0, 1);
        shift_dr(32, 32'h0, dout);
        chk("trst_ir", dout, 32'hDEAD_BEEF);
        shift_ir(5'h07, dout);
        chk("ir_cap2", dout, 32'h1);
        shift_dr(3, 32'b101, dout);
        chk("bypass", dout, 32'b010);
        shift_ir(5'h10, dout);
        shift_dr(2, 32'b01, dout);
        chk("req_set2", 32'(pause_req), 32'd1);
        tms_seq(8'b001, 3);
        chk("mid_state", 32'(tap_state), 32'd4);
        chk("mid_tdo", 32'(jtag_tdo), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(tap_state), 32'd0);
        chk("arst_tdo", 32'(jtag_tdo), 32'd0);
        chk("arst_req", 32'(pause_req), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
